// File: rtl/btn_pkg.sv
// btn_pkg: shared constants, repeat-state enum and width helpers for the button front-end
package btn_pkg;
  localparam int KEY_1     = 11;
  localparam int KEY_2     = 10;
  localparam int KEY_3     = 9;
  localparam int KEY_4     = 8;
  localparam int KEY_5     = 7;
  localparam int KEY_6     = 6;
  localparam int KEY_7     = 5;
  localparam int KEY_8     = 4;
  localparam int KEY_9     = 3;
  localparam int KEY_0     = 2;
  localparam int CUR_LEFT  = 1;
  localparam int CUR_RIGHT = 0;
  localparam int DEBOUNCE_CYCLES_DEF = 10;
  localparam int REPEAT_DELAY_DEF    = 50;
  localparam int REPEAT_PERIOD_DEF   = 10;
  typedef enum logic [1:0] {
    REP_IDLE,
    REP_DELAY,
    REP_PERIOD
  } rep_state_e;
  function automatic int code_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction
  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/btn_debounce_encoder_ch.sv
// btn_debounce_ch: one button channel - 2-flop sync, debounce counter, press pulse,
// and an auto-repeat generator when BTN_AUTO_REPEAT_EN is defined.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BTN_AUTO_REPEAT_EN
  , parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);
  localparam int CW = cnt_w(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          pulse_q, pulse_d;
  logic          accept, press;
  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    accept  = (sync_q[1] != level_q) && (cnt_q == CNT_MAX);
    cnt_d   = ((sync_q[1] == level_q) || accept) ? '0 : cnt_q + 1'b1;
    level_d = accept ? sync_q[1] : level_q;
    press   = level_d & ~level_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end
`ifdef BTN_AUTO_REPEAT_EN
  localparam int RW = cnt_w(max2(REPEAT_DELAY, REPEAT_PERIOD) - 1);
  rep_state_e    rep_q, rep_d;
  logic [RW-1:0] rpt_q, rpt_d;
  logic          fire;
  // Gating fire on level_d keeps a repeat out of the cycle the level falls.
  always_comb begin
    fire    = (rep_q != REP_IDLE) && level_d &&
              (rpt_q == ((rep_q == REP_DELAY) ? RW'(REPEAT_DELAY - 1) : RW'(REPEAT_PERIOD - 1)));
    rep_d   = !level_d ? REP_IDLE : press ? REP_DELAY : fire ? REP_PERIOD : rep_q;
    rpt_d   = (!level_d || press || fire) ? '0 : rpt_q + 1'b1;
    pulse_d = press | fire;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_q <= REP_IDLE;
      rpt_q <= '0;
    end else begin
      rep_q <= rep_d;
      rpt_q <= rpt_d;
    end
  end
`else
  always_comb pulse_d = press;
`endif
  assign btn_level = level_q;
  assign btn_pulse = pulse_q;
endmodule

// File: rtl/btn_debounce_encoder.sv
// btn_debounce_encoder: debounces WIDTH raw buttons and encodes press pulses into a key index.
// Optional auto-repeat is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_debounce_encoder
  import btn_pkg::*;
#(
  parameter int WIDTH           = 12,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           btn_raw,
  output logic [WIDTH-1:0]           btn_level,
  output logic [WIDTH-1:0]           btn_pulse,
  output logic                       key_valid,
  output logic [code_w(WIDTH)-1:0]   key_code,
  output logic                       multi_press
);
  localparam int KW = code_w(WIDTH);
  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce_encoder: invalid debounce/repeat configuration");
  end
  for (genvar c = 0; c < WIDTH; c++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_AUTO_REPEAT_EN
      , .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .btn_raw  (btn_raw[c]),
      .btn_level(btn_level[c]),
      .btn_pulse(btn_pulse[c])
    );
  end
  logic [KW-1:0] key_code_q, key_code_d, low_idx;
  logic          key_valid_q, key_valid_d;
  logic          multi_press_q, multi_press_d;
  // Scan from the top so the lowest set bit wins.
  always_comb begin
    low_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) low_idx = btn_pulse[i] ? KW'(i) : low_idx;
    key_valid_d   = |btn_pulse;
    key_code_d    = key_valid_d ? low_idx : key_code_q;
    multi_press_d = |(btn_pulse & (btn_pulse - 1'b1));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_valid_q   <= 1'b0;
      key_code_q    <= '0;
      multi_press_q <= 1'b0;
    end else begin
      key_valid_q   <= key_valid_d;
      key_code_q    <= key_code_d;
      multi_press_q <= multi_press_d;
    end
  end
  assign key_valid   = key_valid_q;
  assign key_code    = key_code_q;
  assign multi_press = multi_press_q;
endmodule
